uart_bus_master: RTL and testbench

UART_BUS_MASTER -- requirements
Module: uart_bus_master

---
 rtl/uart_bus_master.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// UART-to-bus bridge: 'W'/'R' commands with a big-endian address (and data for writes)
// become one bus transfer; the result goes back as 'K', four read-data bytes, or 'E'.
module uart_bus_master #(
   parameter int BAUD_DIV = 868,
   parameter int TIMEOUT  = 1024
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        RX,
   output logic        TX,
   output logic        req,
   output logic        we,
   output logic [31:0] addr,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   input  logic        gnt,
   input  logic        rvalid,
   input  logic [31:0] rdata,
   input  logic        err,
   output logic        busy
);

   localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
   localparam logic [15:0] HALF_LAST = 16'((BAUD_DIV >> 1) - 1);
   localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [2:0] P_CMD  = 3'd0;
   localparam logic [2:0] P_ADDR = 3'd1;
   localparam logic [2:0] P_DATA = 3'd2;
   localparam logic [2:0] P_REQ  = 3'd3;
   localparam logic [2:0] P_WAIT = 3'd4;
   localparam logic [2:0] P_RESP = 3'd5;

   logic        rx_s1, rx_s2;
   logic [1:0]  rx_state;
   logic [15:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift;
   logic        rx_done, rx_ferr;

   logic [2:0]  p_state;
   logic [1:0]  byte_cnt;
   logic [31:0] tmo_cnt;
   logic [31:0] resp_buf;
   logic [2:0]  resp_n;
   logic [9:0]  tx_shift;
   logic [15:0] tx_cnt;
   logic [3:0]  tx_bitn;
   logic        tx_busy;

   function automatic logic [31:0] resp_word(input logic is_wr, input logic is_err,
                                             input logic [31:0] rd);
      if (is_err)     return {8'h45, 24'h0};
      else if (is_wr) return {8'h4B, 24'h0};
      else            return rd;
   endfunction

   function automatic logic [2:0] resp_len(input logic is_wr, input logic is_err);
      return (is_err || is_wr) ? 3'd1 : 3'd4;
   endfunction

   assign TX = tx_shift[0];
   assign be = 4'b1111;

   // Receiver: 2-flop synchronizer, start-bit recheck at half period, mid-bit sampling
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= 16'd0;
         rx_bit   <= 3'd0;
         rx_done  <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_s1   <= RX;
         rx_s2   <= rx_s1;
         rx_done <= 1'b0;
         rx_ferr <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (!rx_s2) begin
                  rx_state <= RX_START;
                  rx_cnt   <= 16'd0;
               end
            end
            RX_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= 16'd0;
                  rx_bit   <= 3'd0;
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= 16'd0;
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            default: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_done  <= rx_s2;
                  rx_ferr  <= !rx_s2;
                  rx_state <= RX_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
         endcase
      end
   end

   // Command parser, bus handshake and response transmitter
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         p_state  <= P_CMD;
         byte_cnt <= 2'd0;
         tmo_cnt  <= 32'd0;
         req      <= 1'b0;
         we       <= 1'b0;
         addr     <= 32'd0;
         wdata    <= 32'd0;
         busy     <= 1'b0;
         tx_shift <= '1;
         tx_cnt   <= 16'd0;
         tx_bitn  <= 4'd0;
         tx_busy  <= 1'b0;
      end else begin
         case (p_state)
            P_CMD: begin
               if (rx_done && (rx_shift == 8'h57 || rx_shift == 8'h52)) begin
                  we       <= (rx_shift == 8'h57);
                  byte_cnt <= 2'd0;
                  busy     <= 1'b1;
                  p_state  <= P_ADDR;
               end
            end
            P_ADDR: begin
               if (rx_ferr) begin
                  busy    <= 1'b0;
                  p_state <= P_CMD;
               end else if (rx_done) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     addr <= {addr[23:0], rx_shift[7:2], 2'b00};
                     if (we) begin
                        p_state <= P_DATA;
                     end else begin
                        req     <= 1'b1;
                        tmo_cnt <= 32'd0;
                        p_state <= P_REQ;
                     end
                  end else begin
                     addr <= {addr[23:0], rx_shift};
                  end
               end
            end
            P_DATA: begin
               if (rx_ferr) begin
                  busy    <= 1'b0;
                  p_state <= P_CMD;
               end else if (rx_done) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  wdata    <= {wdata[23:0], rx_shift};
                  if (byte_cnt == 2'd3) begin
                     req     <= 1'b1;
                     tmo_cnt <= 32'd0;
                     p_state <= P_REQ;
                  end
               end
            end
            P_REQ: begin
               tmo_cnt <= tmo_cnt + 32'd1;
               if (gnt) begin
                  req <= 1'b0;
                  if (rvalid) begin
                     resp_buf <= resp_word(we, err, rdata);
                     resp_n   <= resp_len(we, err);
                     p_state  <= P_RESP;
                  end else begin
                     p_state <= P_WAIT;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  req      <= 1'b0;
                  resp_buf <= resp_word(we, 1'b1, rdata);
                  resp_n   <= 3'd1;
                  p_state  <= P_RESP;
               end
            end
            P_WAIT: begin
               tmo_cnt <= tmo_cnt + 32'd1;
               if (rvalid) begin
                  resp_buf <= resp_word(we, err, rdata);
                  resp_n   <= resp_len(we, err);
                  p_state  <= P_RESP;
               end else if (tmo_cnt >= TMO_LAST) begin
                  resp_buf <= resp_word(we, 1'b1, rdata);
                  resp_n   <= 3'd1;
                  p_state  <= P_RESP;
               end
            end
            P_RESP: begin
               // Next frame is loaded on the last stop-bit cycle so bytes go out back-to-back
               if (!tx_busy || (tx_cnt == BIT_LAST && tx_bitn == 4'd9 && resp_n != 3'd0)) begin
                  tx_shift <= {1'b1, resp_buf[31:24], 1'b0};
                  resp_buf <= {resp_buf[23:0], 8'h00};
                  resp_n   <= resp_n - 3'd1;
                  tx_busy  <= 1'b1;
                  tx_cnt   <= 16'd0;
                  tx_bitn  <= 4'd0;
               end else if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= 16'd0;
                  if (tx_bitn == 4'd9) begin
                     tx_busy  <= 1'b0;
                     tx_shift <= '1;
                     busy     <= 1'b0;
                     p_state  <= P_CMD;
                  end else begin
                     tx_shift <= {1'b1, tx_shift[9:1]};
                     tx_bitn  <= tx_bitn + 4'd1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            default: p_state <= P_CMD;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: drives UART command frames, models a simple bus
// slave, decodes the TX line and compares against hand-computed values.
module tb_uart_bus_master;

   localparam int BD  = 16;
   localparam int TMO = 64;

   logic        Clk = 1'b0;
   logic        Rst, RX, TX, req, we, gnt, rvalid, err, busy;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  be;

   int          n_chk = 0;
   int          n_fail = 0;
   int          mode = 0;
   logic [31:0] slv_rdata = 32'h0;
   int          hs = 0;
   int          req_cycles = 0;
   int          cyc_cnt = 0;
   logic [31:0] cap_addr, cap_wdata;
   logic        cap_we;
   logic [3:0]  cap_be;
   logic [7:0]  tx_q[$];
   int          st_q[$];

   uart_bus_master #(.BAUD_DIV(BD), .TIMEOUT(TMO)) dut (
      .Clk(Clk), .Rst(Rst), .RX(RX), .TX(TX), .req(req), .we(we), .addr(addr),
      .be(be), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
      .busy(busy)
   );

   initial forever #5 Clk = ~Clk;
   initial forever begin @(posedge Clk); cyc_cnt++; end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_v);
      RX = 1'b0;
      cyc(BD);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         cyc(BD);
      end
      RX = stop_v;
      cyc(BD);
      RX = 1'b1;
      cyc(2);
   endtask

   task automatic send_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4);
      send_byte(b0, 1'b1); send_byte(b1, 1'b1); send_byte(b2, 1'b1);
      send_byte(b3, 1'b1); send_byte(b4, 1'b1);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy !== 1'b0 && k < 4000) begin
         cyc(1);
         k++;
      end
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic clear();
      tx_q.delete();
      st_q.delete();
      hs = 0;
      req_cycles = 0;
   endtask

   // Bus slave: grants (and optionally responds) on the second cycle of a request
   initial begin
      int age = 0;
      gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = 32'h0;
      forever begin
         @(posedge Clk); #1;
         if (req === 1'b1) age++; else age = 0;
         gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
         if (req === 1'b1 && age == 2 && mode != 3) begin
            gnt    = 1'b1;
            rvalid = (mode != 2);
            err    = (mode == 1);
            rdata  = slv_rdata;
         end
      end
   end

   // Bus observer
   initial forever begin
      @(negedge Clk);
      if (req === 1'b1) req_cycles++;
      if (req === 1'b1 && gnt === 1'b1) begin
         hs++;
         cap_addr  = addr;
         cap_wdata = wdata;
         cap_we    = we;
         cap_be    = be;
      end
   end

   // TX line decoder
   initial begin
      logic [7:0] b;
      int st;
      forever begin
         @(negedge Clk);
         if (TX === 1'b0) begin
            st = cyc_cnt;
            repeat (BD / 2) @(negedge Clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BD) @(negedge Clk);
               b[i] = TX;
            end
            repeat (BD) @(negedge Clk);
            tx_q.push_back(b);
            st_q.push_back(st);
         end
      end
   end

   initial begin
      int k;
      Rst = 1'b0;
      RX  = 1'b1;
      cyc(3);
      check("rst_req",   {31'd0, req},  32'd0);
      check("rst_we",    {31'd0, we},   32'd0);
      check("rst_tx",    {31'd0, TX},   32'd1);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_addr",  addr,          32'd0);
      check("rst_wdata", wdata,         32'd0);
      check("rst_be",    {28'd0, be},   32'hF);
      Rst = 1'b1;
      cyc(5);

      // Write 0xDEADBEEF to 0x1004
      clear(); mode = 0;
      send_seq(8'h57, 8'h00, 8'h00, 8'h10, 8'h04);
      send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1);
      send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
      wait_idle("wr");
      check("wr_hs",    hs,                  1);
      check("wr_reqcyc", req_cycles,         2);
      check("wr_we",    {31'd0, cap_we},     32'd1);
      check("wr_addr",  cap_addr,            32'h00001004);
      check("wr_wdata", cap_wdata,           32'hDEADBEEF);
      check("wr_be",    {28'd0, cap_be},     32'hF);
      check("wr_txn",   tx_q.size(),         1);
      check("wr_txb",   {24'd0, tx_q[0]},    32'h4B);

      // Read from unaligned 0x1007 -> 0x1004
      clear(); mode = 0; slv_rdata = 32'h12345678;
      send_seq(8'h52, 8'h00, 8'h00, 8'h10, 8'h07);
      wait_idle("rd");
      check("rd_hs",   hs,               1);
      check("rd_we",   {31'd0, cap_we},  32'd0);
      check("rd_addr", cap_addr,         32'h00001004);
      check("rd_txn",  tx_q.size(),      4);
      if (tx_q.size() == 4) begin
         check("rd_b0", {24'd0, tx_q[0]}, 32'h12);
         check("rd_b1", {24'd0, tx_q[1]}, 32'h34);
         check("rd_b2", {24'd0, tx_q[2]}, 32'h56);
         check("rd_b3", {24'd0, tx_q[3]}, 32'h78);
         for (int i = 1; i < 4; i++)
            check("rd_gap", st_q[i] - st_q[i-1], 10 * BD);
      end

      // Slave error
      clear(); mode = 1;
      send_seq(8'h52, 8'h00, 8'h00, 8'h00, 8'h20);
      wait_idle("err");
      check("err_addr", cap_addr,         32'h00000020);
      check("err_txn",  tx_q.size(),      1);
      check("err_txb",  {24'd0, tx_q[0]}, 32'h45);

      // Granted, rvalid never arrives
      clear(); mode = 2;
      send_seq(8'h52, 8'h00, 8'h00, 8'h00, 8'h30);
      wait_idle("tmog");
      check("tmog_hs",  hs,               1);
      check("tmog_txn", tx_q.size(),      1);
      check("tmog_txb", {24'd0, tx_q[0]}, 32'h45);

      // Never granted: req held exactly TIMEOUT cycles
      clear(); mode = 3;
      send_seq(8'h52, 8'h00, 8'h00, 8'h00, 8'h40);
      wait_idle("tmo");
      check("tmo_hs",     hs,               0);
      check("tmo_reqcyc", req_cycles,       TMO);
      check("tmo_req",    {31'd0, req},     32'd0);
      check("tmo_txb",    {24'd0, tx_q[0]}, 32'h45);

      // Short low glitch in the middle of an address must not become a byte
      clear(); mode = 0; slv_rdata = 32'hCAFEF00D;
      send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
      RX = 1'b0; cyc(BD / 4); RX = 1'b1; cyc(3 * BD);
      send_byte(8'h10, 1'b1); send_byte(8'h04, 1'b1);
      wait_idle("noise");
      check("noise_hs",   hs,          1);
      check("noise_addr", cap_addr,    32'h00001004);
      check("noise_txn",  tx_q.size(), 4);

      // Framing error on address byte 2 aborts the command
      clear(); mode = 0;
      send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b0);
      cyc(12 * BD);
      send_byte(8'h10, 1'b1); send_byte(8'h04, 1'b1);
      cyc(20 * BD);
      check("fe_hs",     hs,              0);
      check("fe_reqcyc", req_cycles,      0);
      check("fe_busy",   {31'd0, busy},   32'd0);
      check("fe_txn",    tx_q.size(),     0);

      // Garbage byte first, then a read with an extra byte during the response
      clear(); mode = 0; slv_rdata = 32'hA1B2C3D4;
      send_byte(8'h00, 1'b1);
      send_seq(8'h52, 8'h00, 8'h00, 8'h10, 8'h04);
      k = 0;
      while (tx_q.size() == 0 && k < 2000) begin cyc(1); k++; end
      send_byte(8'h52, 1'b1);
      wait_idle("ovl");
      cyc(20 * BD);
      check("ovl_hs",   hs,               1);
      check("ovl_addr", cap_addr,         32'h00001004);
      check("ovl_txn",  tx_q.size(),      4);
      check("ovl_b3",   {24'd0, tx_q[3]}, 32'hD4);
      check("ovl_busy", {31'd0, busy},    32'd0);

      // Reset while req is held
      clear(); mode = 3;
      send_seq(8'h52, 8'h00, 8'h00, 8'h00, 8'h50);
      k = 0;
      while (req !== 1'b1 && k < 2000) begin cyc(1); k++; end
      check("rr_req_seen", {31'd0, req}, 32'd1);
      Rst = 1'b0; cyc(1);
      check("rr_req",  {31'd0, req},  32'd0);
      check("rr_tx",   {31'd0, TX},   32'd1);
      check("rr_busy", {31'd0, busy}, 32'd0);
      Rst = 1'b1; cyc(2);

      // Reset while TX is mid-byte
      mode = 0; slv_rdata = 32'h00FF00FF;
      send_seq(8'h52, 8'h00, 8'h00, 8'h00, 8'h60);
      k = 0;
      while (TX !== 1'b0 && k < 2000) begin cyc(1); k++; end
      check("rt_tx_start", {31'd0, TX}, 32'd0);
      cyc(3 * BD);
      Rst = 1'b0; cyc(1);
      check("rt_tx",   {31'd0, TX},   32'd1);
      check("rt_busy", {31'd0, busy}, 32'd0);
      check("rt_req",  {31'd0, req},  32'd0);
      Rst = 1'b1;
      cyc(12 * BD);
      clear();

      // Normal write after reset
      mode = 0;
      send_seq(8'h57, 8'h00, 8'h00, 8'h00, 8'h0A);
      send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
      wait_idle("rec");
      check("rec_hs",    hs,               1);
      check("rec_addr",  cap_addr,         32'h00000008);
      check("rec_wdata", cap_wdata,        32'h01020304);
      check("rec_txb",   {24'd0, tx_q[0]}, 32'h4B);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
